// File: rtl/ctrl_pkg.sv
// Shared constants for the control-bundle pipeline: aluop codes, default widths
// and the multi-cycle counter width helper.
package ctrl_pkg;
    localparam logic [3:0] ALUOP_MUL = 4'b1111;
    localparam logic [3:0] ALUOP_DIV = 4'b1110;

    localparam int EX_W_DEF      = 11;
    localparam int MEM_W_DEF     = 5;
    localparam int WB_W_DEF      = 2;
    localparam int ALUOP_LSB_DEF = 5;

    // Never returns 0 so the counter stays a legal vector when both latencies are 1.
    function automatic int cnt_width(input int mul_lat, input int div_lat);
        int m;
        m = (mul_lat > div_lat) ? mul_lat : div_lat;
        return (m > 1) ? $clog2(m) : 1;
    endfunction
endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline register: valid bit plus a control bundle. Hold wins over bubble;
// an invalid entry is always stored with an all-zero bundle.
module ctrl_stage_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         hold,
    input  logic         bubble,
    input  logic [W-1:0] d,
    input  logic         valid_in,
    output logic [W-1:0] q,
    output logic         valid_out
);
    logic [W-1:0] q_q, q_d;
    logic         valid_q, valid_d;

    always_comb begin
        q_d     = q_q;
        valid_d = valid_q;
        if (!hold) begin
            if (bubble || !valid_in) begin
                q_d     = '0;
                valid_d = 1'b0;
            end else begin
                q_d     = d;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            valid_q <= valid_d;
        end
    end

    assign q         = q_q;
    assign valid_out = valid_q;
endmodule

// File: rtl/ctrl_pipe.sv
// Carries decoded EX/MEM/WB control bundles through ID/EX, EX/MEM and MEM/WB,
// inserting bubbles for stall/flush/undef and holding EX for multi-cycle mul/div.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int EX_W      = EX_W_DEF,
    parameter int MEM_W     = MEM_W_DEF,
    parameter int WB_W      = WB_W_DEF,
    parameter int ALUOP_LSB = ALUOP_LSB_DEF,
    parameter int MUL_LAT   = 4,
    parameter int DIV_LAT   = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             dec_valid,
    input  logic             dec_undef,
    input  logic [EX_W-1:0]  dec_ex,
    input  logic [MEM_W-1:0] dec_mem,
    input  logic [WB_W-1:0]  dec_wb,
    input  logic             stall_in,
    input  logic             flush_in,
    output logic             ex_valid,
    output logic [EX_W-1:0]  ex_control,
    output logic             mem_valid,
    output logic [MEM_W-1:0] mem_control,
    output logic             wb_valid,
    output logic [WB_W-1:0]  wb_control,
    output logic             stall_dec,
    output logic             busy,
    output logic             exc_undef
);
    localparam int ID_W  = EX_W + MEM_W + WB_W;
    localparam int EM_W  = MEM_W + WB_W;
    localparam int CNT_W = cnt_width(MUL_LAT, DIV_LAT);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    logic [ID_W-1:0]  idex_q;
    logic [EM_W-1:0]  exmem_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             exc_q, exc_d;
    logic             ex_hold;
    logic             id_bubble;
    logic [3:0]       dec_aluop;

    assign busy      = ex_valid && (count_q != '0);
    assign ex_hold   = busy;
    assign stall_dec = stall_in || ex_hold;
    assign id_bubble = flush_in || stall_in || dec_undef;
    assign dec_aluop = dec_ex[ALUOP_LSB +: 4];

    // count_q is the number of further EX cycles the current op still needs.
    always_comb begin
        count_d = '0;
        if (ex_hold) begin
            count_d = count_q - CNT_W'(1);
        end else if (dec_valid && !id_bubble) begin
            if (dec_aluop == ALUOP_MUL)      count_d = MUL_CNT;
            else if (dec_aluop == ALUOP_DIV) count_d = DIV_CNT;
        end
    end

    assign exc_d = dec_valid && dec_undef && !stall_in && !flush_in && !ex_hold;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            exc_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            exc_q   <= exc_d;
        end
    end

    assign exc_undef = exc_q;

    ctrl_stage_reg #(.W(ID_W)) u_idex (
        .clk       (clk),
        .reset_n   (reset_n),
        .hold      (ex_hold),
        .bubble    (id_bubble),
        .d         ({dec_ex, dec_mem, dec_wb}),
        .valid_in  (dec_valid),
        .q         (idex_q),
        .valid_out (ex_valid)
    );

    ctrl_stage_reg #(.W(EM_W)) u_exmem (
        .clk       (clk),
        .reset_n   (reset_n),
        .hold      (1'b0),
        .bubble    (ex_hold),
        .d         (idex_q[EM_W-1:0]),
        .valid_in  (ex_valid),
        .q         (exmem_q),
        .valid_out (mem_valid)
    );

    ctrl_stage_reg #(.W(WB_W)) u_memwb (
        .clk       (clk),
        .reset_n   (reset_n),
        .hold      (1'b0),
        .bubble    (1'b0),
        .d         (exmem_q[WB_W-1:0]),
        .valid_in  (mem_valid),
        .q         (wb_control),
        .valid_out (wb_valid)
    );

    assign ex_control  = idex_q[ID_W-1 -: EX_W];
    assign mem_control = exmem_q[EM_W-1 -: MEM_W];
endmodule

// File: tb/tb_ctrl_pipe.sv
// Randomised and directed bench for ctrl_pipe against a per-instruction
// occupancy model (each EX entry tracks its latency and how long it has been there).
module tb_ctrl_pipe;
    localparam int EX_W   = 11;
    localparam int MEM_W  = 5;
    localparam int WB_W   = 2;
    localparam int LSB    = 5;
    localparam int TB_MUL = 1;
    localparam int TB_DIV = 32;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             dec_valid, dec_undef, stall_in, flush_in;
    logic [EX_W-1:0]  dec_ex;
    logic [MEM_W-1:0] dec_mem;
    logic [WB_W-1:0]  dec_wb;
    logic             ex_valid, mem_valid, wb_valid;
    logic [EX_W-1:0]  ex_control;
    logic [MEM_W-1:0] mem_control;
    logic [WB_W-1:0]  wb_control;
    logic             stall_dec, busy, exc_undef;

    ctrl_pipe #(
        .EX_W(EX_W), .MEM_W(MEM_W), .WB_W(WB_W), .ALUOP_LSB(LSB),
        .MUL_LAT(TB_MUL), .DIV_LAT(TB_DIV)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .dec_valid(dec_valid), .dec_undef(dec_undef),
        .dec_ex(dec_ex), .dec_mem(dec_mem), .dec_wb(dec_wb),
        .stall_in(stall_in), .flush_in(flush_in),
        .ex_valid(ex_valid), .ex_control(ex_control),
        .mem_valid(mem_valid), .mem_control(mem_control),
        .wb_valid(wb_valid), .wb_control(wb_control),
        .stall_dec(stall_dec), .busy(busy), .exc_undef(exc_undef)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic             m_ex_v;
    logic [EX_W-1:0]  m_ex_ex;
    logic [MEM_W-1:0] m_ex_mem;
    logic [WB_W-1:0]  m_ex_wb;
    int               m_ex_lat, m_ex_age;
    logic             m_mem_v;
    logic [MEM_W-1:0] m_mem_mem;
    logic [WB_W-1:0]  m_mem_wb;
    logic             m_wb_v;
    logic [WB_W-1:0]  m_wb_wb;
    logic             m_exc;

    logic last_stall_dec, last_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lat_of(input logic [3:0] op);
        if (op == 4'b1111) return TB_MUL;
        if (op == 4'b1110) return TB_DIV;
        return 1;
    endfunction

    function automatic logic exp_busy();
        return m_ex_v && (m_ex_age < m_ex_lat);
    endfunction

    function automatic logic [EX_W-1:0] mk_ex(input logic [3:0] op, input logic [EX_W-1:0] rnd);
        logic [EX_W-1:0] e;
        e = rnd;
        e[LSB +: 4] = op;
        return e;
    endfunction

    task automatic model_reset();
        m_ex_v = 1'b0; m_ex_ex = '0; m_ex_mem = '0; m_ex_wb = '0;
        m_ex_lat = 1; m_ex_age = 0;
        m_mem_v = 1'b0; m_mem_mem = '0; m_mem_wb = '0;
        m_wb_v = 1'b0; m_wb_wb = '0;
        m_exc = 1'b0;
    endtask

    task automatic model_step();
        logic hold;
        logic [EX_W-1:0] e;
        hold = exp_busy();
        m_wb_v  = m_mem_v;
        m_wb_wb = m_mem_wb;
        if (hold) begin
            m_mem_v = 1'b0; m_mem_mem = '0; m_mem_wb = '0;
            m_ex_age++;
        end else begin
            m_mem_v = m_ex_v; m_mem_mem = m_ex_mem; m_mem_wb = m_ex_wb;
            if (dec_valid && !dec_undef && !stall_in && !flush_in) begin
                e = dec_ex;
                m_ex_v = 1'b1; m_ex_ex = dec_ex; m_ex_mem = dec_mem; m_ex_wb = dec_wb;
                m_ex_lat = lat_of(e[LSB +: 4]);
                m_ex_age = 1;
            end else begin
                m_ex_v = 1'b0; m_ex_ex = '0; m_ex_mem = '0; m_ex_wb = '0;
                m_ex_lat = 1; m_ex_age = 0;
            end
        end
        m_exc = dec_valid && dec_undef && !stall_in && !flush_in && !hold;
    endtask

    task automatic compare_all();
        check("ex_valid",    32'(ex_valid),    32'(m_ex_v));
        check("ex_control",  32'(ex_control),  32'(m_ex_ex));
        check("mem_valid",   32'(mem_valid),   32'(m_mem_v));
        check("mem_control", 32'(mem_control), 32'(m_mem_mem));
        check("wb_valid",    32'(wb_valid),    32'(m_wb_v));
        check("wb_control",  32'(wb_control),  32'(m_wb_wb));
        check("busy",        32'(busy),        32'(exp_busy()));
        check("stall_dec",   32'(stall_dec),   32'(stall_in || exp_busy()));
        check("exc_undef",   32'(exc_undef),   32'(m_exc));
    endtask

    // One clock: called just after a negedge, returns just after the next negedge.
    task automatic cycle(input logic v, input logic u, input logic [EX_W-1:0] ex,
                         input logic [MEM_W-1:0] mem, input logic [WB_W-1:0] wb,
                         input logic st, input logic fl);
        dec_valid = v; dec_undef = u; dec_ex = ex; dec_mem = mem; dec_wb = wb;
        stall_in = st; flush_in = fl;
        #1;
        compare_all();
        last_stall_dec = stall_dec;
        last_busy      = busy;
        if (wb_valid)
            $display("t=%0t retire wb_control=%b", $time, wb_control);
        @(posedge clk);
        if (reset_n) model_step();
        else         model_reset();
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    logic [EX_W-1:0] addu_ex, div_ex, mul_ex, lw_ex, rnd_ex;
    logic [3:0]      rop;
    int              busy_cnt, bub_cnt, iter;
    logic            seen;

    initial begin
        reset_n = 1'b0;
        dec_valid = 1'b0; dec_undef = 1'b0; stall_in = 1'b0; flush_in = 1'b0;
        dec_ex = '0; dec_mem = '0; dec_wb = '0;
        model_reset();
        addu_ex = mk_ex(4'b0010, 11'h003);
        div_ex  = mk_ex(4'b1110, 11'h011);
        mul_ex  = mk_ex(4'b1111, 11'h005);
        lw_ex   = mk_ex(4'b0000, 11'h401);
        @(negedge clk);
        idle(); idle();
        reset_n = 1'b1;
        idle();

        // Reset mid-stream with addu in EX
        cycle(1'b1, 1'b0, addu_ex, 5'b00000, 2'b10, 1'b0, 1'b0);
        check("pre_rst_ex_valid", 32'(ex_valid), 32'(1));
        reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_async_ex_valid", 32'(ex_valid), 32'(0));
        compare_all();
        @(negedge clk);
        reset_n = 1'b1;
        $display("t=%0t reset mid-stream released", $time);
        cycle(1'b1, 1'b0, addu_ex, 5'b00000, 2'b10, 1'b0, 1'b0);
        idle(); idle();
        check("rst_addu_wb_valid", 32'(wb_valid), 32'(1));
        check("rst_addu_wb_ctrl",  32'(wb_control), 32'(2'b10));

        // Load-use stall
        cycle(1'b1, 1'b0, lw_ex, 5'b01000, 2'b11, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, addu_ex, 5'b00000, 2'b10, 1'b1, 1'b0);
        check("lu_stall_dec", 32'(last_stall_dec), 32'(1));
        check("lu_bubble_ex_valid", 32'(ex_valid), 32'(0));
        cycle(1'b1, 1'b0, addu_ex, 5'b00000, 2'b10, 1'b0, 1'b0);
        check("lu_addu_late", 32'(ex_control), 32'(addu_ex));
        $display("t=%0t load-use transaction done", $time);

        // Flush of a sw in decode
        cycle(1'b1, 1'b0, addu_ex, 5'b10000, 2'b00, 1'b0, 1'b1);
        check("flush_ex_valid", 32'(ex_valid), 32'(0));
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (mem_control == 5'b10000) seen = 1'b1;
            idle();
        end
        check("flush_no_sw_mem", 32'(seen), 32'(0));
        $display("t=%0t flush transaction done", $time);

        // divu with DIV_LAT=32
        idle(); idle(); idle();
        cycle(1'b1, 1'b0, div_ex, 5'b00001, 2'b01, 1'b0, 1'b0);
        busy_cnt = 0; bub_cnt = 0; iter = 0;
        while (!(mem_valid && mem_control == 5'b00001) && iter < 40) begin
            if (busy) busy_cnt++;
            if (!mem_valid && iter > 0) bub_cnt++;
            cycle(1'b1, 1'b0, addu_ex, 5'b00000, 2'b10, 1'b0, 1'b0);
            iter++;
        end
        check("div_busy_cycles", 32'(busy_cnt), 32'(TB_DIV - 1));
        check("div_mem_bubbles", 32'(bub_cnt), 32'(TB_DIV - 1));
        check("div_ex_cycles",   32'(iter), 32'(TB_DIV));
        check("div_addu_in_ex",  32'(ex_control), 32'(addu_ex));
        $display("t=%0t divu transaction done, busy %0d cycles", $time, busy_cnt);

        // mul with MUL_LAT=1 never asserts busy
        cycle(1'b1, 1'b0, mul_ex, 5'b00000, 2'b10, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (busy) seen = 1'b1;
            idle();
        end
        check("mul_lat1_busy", 32'(seen), 32'(0));
        $display("t=%0t mul transaction done", $time);

        // Undefined instruction: accepted, then under stall
        cycle(1'b1, 1'b1, addu_ex, 5'b00000, 2'b10, 1'b0, 1'b0);
        check("undef_exc",      32'(exc_undef), 32'(1));
        check("undef_ex_valid", 32'(ex_valid),  32'(0));
        idle();
        check("undef_exc_one_cycle", 32'(exc_undef), 32'(0));
        cycle(1'b1, 1'b1, addu_ex, 5'b00000, 2'b10, 1'b1, 1'b0);
        check("undef_stalled_exc", 32'(exc_undef), 32'(0));
        idle();
        $display("t=%0t undef transactions done", $time);

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            iter = int'($urandom_range(0, 99));
            if (iter < 3)       rop = 4'b1110;
            else if (iter < 13) rop = 4'b1111;
            else                rop = 4'($urandom_range(0, 13));
            rnd_ex = 11'($urandom);
            cycle(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0),
                  mk_ex(rop, rnd_ex), 5'($urandom), 2'($urandom),
                  1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0));
        end
        for (int i = 0; i < 40; i++) idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
